// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF engine.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RACE,
        STORE,
        DONE
    } puf_state_t;

    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    // Right-shifting Fibonacci taps: bit index = width - polynomial exponent
    localparam logic [15:0] LFSR_TAPS_16 = 16'h002D;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [63:0] lfsr_taps(input int unsigned w);
        logic [63:0] t;
        case (w)
            8:       t = 64'h1D;
            32:      t = 64'hC000_0401;
            default: t = 64'(LFSR_TAPS_16);
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ro_race_counter.sv
// Synchronizes the whole oscillator bank and races two selected edge counters.
module ro_race_counter
    import puf_pkg::*;
#(
    parameter int unsigned NUM_RO   = 16,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned RACE_CNT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RO-1:0]         ro_in,
    input  logic [clog2(NUM_RO)-1:0]  sel_a,
    input  logic [clog2(NUM_RO)-1:0]  sel_b,
    input  logic                      clr,
    input  logic                      en,
    output logic [CNT_W-1:0]          cnt_a,
    output logic [CNT_W-1:0]          cnt_b,
    output logic                      win_a,
    output logic                      win_b
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(RACE_CNT);

    logic [NUM_RO-1:0] sync1, sync2, prev, rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (en) begin
            if (rise[sel_a] && cnt_a != CNT_MAX) cnt_a <= cnt_a + CNT_W'(1);
            if (rise[sel_b] && cnt_b != CNT_MAX) cnt_b <= cnt_b + CNT_W'(1);
        end
    end

    assign win_a = (cnt_a >= THRESH);
    assign win_b = (cnt_b >= THRESH);

endmodule

// File: rtl/ro_puf_engine.sv
// Handshaked ring-oscillator PUF: LFSR-scrambled oscillator pairs race per response bit.
module ro_puf_engine
    import puf_pkg::*;
#(
    parameter int unsigned CHALL_W  = 8,
    parameter int unsigned RESP_W   = 8,
    parameter int unsigned NUM_RO   = 16,
    parameter int unsigned LFSR_W   = 16,
    parameter int unsigned RACE_CNT = 64,
    parameter int unsigned TIMEOUT  = 4096,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CHALL_W-1:0] chall_in,
    input  logic [NUM_RO-1:0]  ro_in,
    output logic [RESP_W-1:0]  response,
    output logic               ready,
    output logic               done,
    output logic               err
);

    localparam int unsigned S     = clog2(NUM_RO);
    localparam int unsigned TMR_W = clog2(TIMEOUT) + 1;
    localparam int unsigned IDX_W = (RESP_W > 1) ? clog2(RESP_W) : 1;
    localparam logic [LFSR_W-1:0] SEED     = LFSR_W'(LFSR_SEED);
    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(RESP_W - 1);

    puf_state_t state, state_nxt;

    logic [LFSR_W-1:0] lfsr, lfsr_shift, seed_raw, seed;
    logic [S-1:0]      sel_a, sel_b, nxt_a, nxt_b;
    logic [TMR_W-1:0]  timer;
    logic [IDX_W-1:0]  bit_idx;
    logic [RESP_W-1:0] shadow;
    logic              race_bit;
    logic [CNT_W-1:0]  cnt_a, cnt_b;
    logic              win_a, win_b;
    logic              accept, race_end, race_val, timed_out;

    ro_race_counter #(
        .NUM_RO   (NUM_RO),
        .CNT_W    (CNT_W),
        .RACE_CNT (RACE_CNT)
    ) u_race (
        .clk   (clk),
        .rst   (rst),
        .ro_in (ro_in),
        .sel_a (sel_a),
        .sel_b (sel_b),
        .clr   (state == SELECT),
        .en    (state == RACE),
        .cnt_a (cnt_a),
        .cnt_b (cnt_b),
        .win_a (win_a),
        .win_b (win_b)
    );

    assign seed_raw   = LFSR_W'(chall_in) ^ SEED;
    assign seed       = (seed_raw == '0) ? SEED : seed_raw;
    assign lfsr_shift = {^(lfsr & TAPS), lfsr[LFSR_W-1:1]};
    assign nxt_a      = lfsr_shift[S-1:0];
    assign nxt_b      = (lfsr_shift[2*S-1:S] == nxt_a) ? (nxt_a ^ S'(1)) : lfsr_shift[2*S-1:S];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        race_end  = 1'b0;
        race_val  = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SELECT;
                end
            end
            SELECT: state_nxt = RACE;
            RACE: begin
                // A simultaneous win resolves to 0, same as B winning outright
                if (win_a || win_b) begin
                    race_end = 1'b1;
                    race_val = win_a & ~win_b;
                end else if (timer == TMR_LAST) begin
                    race_end  = 1'b1;
                    race_val  = (cnt_a > cnt_b);
                    timed_out = 1'b1;
                end
                if (race_end) state_nxt = STORE;
            end
            STORE:   state_nxt = (bit_idx == IDX_LAST) ? DONE : SELECT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= SEED;
            sel_a    <= '0;
            sel_b    <= '0;
            timer    <= '0;
            bit_idx  <= '0;
            shadow   <= '0;
            race_bit <= 1'b0;
            response <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (accept) begin
                lfsr    <= seed;
                bit_idx <= '0;
                err     <= 1'b0;
            end
            if (state == SELECT) begin
                lfsr  <= lfsr_shift;
                sel_a <= nxt_a;
                sel_b <= nxt_b;
                timer <= '0;
            end
            if (state == RACE) begin
                timer <= timer + TMR_W'(1);
                if (race_end)  race_bit <= race_val;
                if (timed_out) err      <= 1'b1;
            end
            if (state == STORE) begin
                shadow[bit_idx] <= race_bit;
                if (bit_idx != IDX_LAST) bit_idx <= bit_idx + IDX_W'(1);
            end
            if (state == DONE) response <= shadow;
        end
    end

endmodule

// File: tb/tb_ro_puf_engine.sv
// Directed and randomized checks of ro_puf_engine against a behavioural LFSR/race model.
module tb_ro_puf_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_m, start_t;
    logic [15:0] chall_m;
    logic [7:0]  chall_t;
    logic [15:0] ro_in = '0;
    logic [7:0]  resp_m, resp_t;
    logic        ready_m, done_m, err_m, ready_t, done_t, err_t;

    int tests  = 0;
    int failed = 0;
    int mode   = 0;
    int tcnt   = 0;
    logic sq   = 1'b0;

    ro_puf_engine #(.CHALL_W(16), .RESP_W(8), .NUM_RO(16), .LFSR_W(16),
                    .RACE_CNT(32), .TIMEOUT(4096), .CNT_W(16)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .chall_in(chall_m), .ro_in(ro_in),
        .response(resp_m), .ready(ready_m), .done(done_m), .err(err_m));

    ro_puf_engine #(.CHALL_W(8), .RESP_W(8), .NUM_RO(16), .LFSR_W(16),
                    .RACE_CNT(4), .TIMEOUT(32), .CNT_W(8)) dut_t (
        .clk(clk), .rst(rst), .start(start_t), .chall_in(chall_t), .ro_in(ro_in),
        .response(resp_t), .ready(ready_t), .done(done_t), .err(err_t));

    // Bank stimulus: 0 = all low, 1 = ro_in[k] toggles every 2+k cycles, 2 = one shared period-8 wave
    always @(negedge clk) begin
        tcnt++;
        if (mode == 1) begin
            for (int k = 0; k < 16; k++)
                if (tcnt % (2 + k) == 0) ro_in[k] = ~ro_in[k];
        end else if (mode == 2) begin
            if (tcnt % 4 == 0) sq = ~sq;
            ro_in = {16{sq}};
        end else begin
            ro_in = '0;
        end
    end

    // Lower index oscillates faster, so the lower selected index wins each race
    function automatic logic [7:0] model_resp(input logic [15:0] ch);
        int unsigned l, fb, a, b;
        logic [7:0] r;
        r = '0;
        l = 32'(ch) ^ 32'hACE1;
        if (l == 0) l = 32'hACE1;
        for (int i = 0; i < 8; i++) begin
            fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
            l  = (l >> 1) | (fb << 15);
            a  = l % 16;
            b  = (l / 16) % 16;
            if (a == b) b = a ^ 1;
            r[i] = (a < b);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int which, input logic [15:0] ch, input int inject_at,
                       output logic [7:0] resp, output logic e_acc, output logic e_end,
                       output int ndone, output int lat);
        ndone = 0;
        lat   = -1;
        if (which == 0) begin chall_m = ch; start_m = 1'b1; end
        else            begin chall_t = ch[7:0]; start_t = 1'b1; end
        @(negedge clk);
        start_m = 1'b0;
        start_t = 1'b0;
        e_acc = (which == 0) ? err_m : err_t;
        for (int n = 1; n <= 12000; n++) begin
            @(negedge clk);
            start_m = 1'b0;
            start_t = 1'b0;
            if (n == inject_at) begin
                chall_m = 16'hFFFF;
                chall_t = 8'hFF;
                if (which == 0) start_m = 1'b1; else start_t = 1'b1;
            end
            if ((which == 0) ? done_m : done_t) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n >= lat + 5) break;
        end
        resp  = (which == 0) ? resp_m : resp_t;
        e_end = (which == 0) ? err_m : err_t;
    endtask

    initial begin
        logic [7:0]  r, exp;
        logic [15:0] ch;
        logic        ea, ee;
        int          nd, lat;

        rst = 1'b1; start_m = 1'b0; start_t = 1'b0; chall_m = '0; chall_t = '0;
        repeat (2) @(negedge clk);
        check("rst_ready_m", 32'(ready_m), 1);
        check("rst_done_m",  32'(done_m), 0);
        check("rst_err_m",   32'(err_m), 0);
        check("rst_resp_m",  32'(resp_m), 0);
        check("rst_ready_t", 32'(ready_t), 1);
        check("rst_done_t",  32'(done_t), 0);
        check("rst_err_t",   32'(err_t), 0);
        check("rst_resp_t",  32'(resp_t), 0);
        rst  = 1'b0;
        mode = 1;
        repeat (40) @(negedge clk);

        run(0, 16'h005A, 150, r, ea, ee, nd, lat);
        check("ord5A_busy_resp", 32'(r), 32'(model_resp(16'h005A)));
        check("ord5A_err",       32'(ee), 0);
        check("ord5A_done_once", nd, 1);

        run(0, 16'h005A, 0, r, ea, ee, nd, lat);
        check("repeat5A_resp", 32'(r), 32'(model_resp(16'h005A)));
        check("repeat5A_done", nd, 1);

        for (int i = 0; i < 2; i++) begin
            ch = 16'($urandom_range(0, 65535));
            run(0, ch, 0, r, ea, ee, nd, lat);
            check("rand_resp", 32'(r), 32'(model_resp(ch)));
            check("rand_err",  32'(ee), 0);
        end

        exp = model_resp(16'h0000);
        run(0, 16'h0000, 0, r, ea, ee, nd, lat);
        check("chall0_resp", 32'(r), 32'(exp));
        run(0, 16'hACE1, 0, r, ea, ee, nd, lat);
        check("zero_seed_resp", 32'(r), 32'(exp));

        // Abort a run in RACE with reset
        chall_m = 16'h005A;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(ready_m), 1);
        check("midrst_resp",  32'(resp_m), 0);
        check("midrst_err",   32'(err_m), 0);
        nd = 0;
        repeat (300) begin
            @(negedge clk);
            if (done_m) nd++;
        end
        check("midrst_no_done", nd, 0);

        mode = 2;
        repeat (20) @(negedge clk);
        run(0, 16'($urandom_range(0, 65535)), 0, r, ea, ee, nd, lat);
        check("tie_resp", 32'(r), 0);
        check("tie_err",  32'(ee), 0);
        check("tie_done", nd, 1);

        mode = 0;
        repeat (10) @(negedge clk);
        run(1, 16'h003C, 0, r, ea, ee, nd, lat);
        check("to_resp",    32'(r), 0);
        check("to_err",     32'(ee), 1);
        check("to_latency", lat, 8 * 34 + 1);
        check("to_done",    nd, 1);

        run(1, 16'h00C3, 100, r, ea, ee, nd, lat);
        check("to2_err_cleared", 32'(ea), 0);
        check("to2_err_set",     32'(ee), 1);
        check("to2_busy_lat",    lat, 8 * 34 + 1);
        check("to2_done",        nd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
